pipe_stage_buffer: RTL and testbench
====================================

// Module: pipe_stage_buffer
// PURPOSE
//  Generic parametrised pipeline stage buffer (IF/ID, ID/EX, EX/MEM, MEM/WB successor).
//  Carries a data bundle plus a control bundle between stages with valid/ready handshake.
//  Adds stall (back-pressure), flush (bubble insertion) and an optional 2-entry skid slot for a registered in_ready.
//  Control bits (RegWrite, MemtoReg, ...) are forced to 0 whenever the stage holds a bubble.
// PARAMETERS
//  DATA_W  64  width of data bundle (e.g. ReadData+ALUResult)
//  CTRL_W  2   width of control bundle; zeroed on bubble/flush/reset
//  SKID    1   1: two-entry skid buffer with registered in_ready; 0: single register, combinational in_ready
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous bubble insertion; discards all held entries
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept an entry this cycle
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  in_wreg    in   5       destination register index
//  out_valid  out  1       stage presents a valid entry
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_ctrl   out  CTRL_W  control bundle; 0 when out_valid=0
//  out_data   out  DATA_W  data bundle
//  out_wreg   out  5       destination register index; 0 when out_valid=0
//  occupancy  out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high, port name reset.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset: state EMPTY; out_valid=0, out_ctrl=0, out_wreg=0, out_data=0, occupancy=0, in_ready=1 on the following cycle.
//  - Latency: an accepted entry appears at the outputs exactly 1 cycle after in_fire (EMPTY, or BUSY with out_fire).
//  - FSM (SKID=1), states EMPTY/BUSY/FULL; main slot drives outputs, skid slot holds overflow:
//     EMPTY: in_fire -> BUSY (main<=in); else stay.
//     BUSY : in_fire&!out_fire -> FULL (skid<=in); !in_fire&out_fire -> EMPTY;
//            in_fire&out_fire -> BUSY (main<=in); neither -> hold.
//     FULL : out_fire -> BUSY (main<=skid); else hold. in_fire impossible (in_ready=0).
//  - in_ready (SKID=1) is a register: 1 in EMPTY/BUSY, 0 in FULL; no combinational in->out path.
//  - SKID=0: states EMPTY/BUSY only; in_ready = !out_valid | out_ready (combinational); FULL unreachable.
//  - Stall: out_ready=0 holds the outputs bit-stable for every cycle out_valid=1.
//  - Flush: priority over all handshake events (reset over flush). Next cycle: EMPTY, out_valid=0,
//    out_ctrl=0, out_wreg=0, occupancy=0; an in_fire in the flush cycle is dropped; out_data unchanged.
//  - out_ctrl/out_wreg are registered 0 whenever the state is EMPTY (no stale RegWrite after drain).
//  - occupancy = 0/1/2 for EMPTY/BUSY/FULL; reflects the registered state.
//  - Ordering: entries leave strictly in acceptance order; no entry is duplicated or lost except by flush/reset.
//  - Reset or flush mid-stall: discards the held entry; no handshake outputs are asserted the next cycle except in_ready.
// STRUCTURE
//  - Shared package pipe_pkg: localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2; REG_IDX_W=5.
//  - Single module; slot storage as two {ctrl,wreg,data} registers; SKID selected with a generate block.
//  - No sub-module required; a pipe_slot helper for the {ctrl,wreg,data} register is allowed but not needed.
// TESTING
//  1. Reset: reset=1 two cycles, then 0 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
//  2. Streaming: out_ready=1, send data 0x11..0x15, ctrl=2'b11 back-to-back -> same sequence out 1 cycle later, in_ready stays 1.
//  3. Stall (SKID=1): out_ready=0, push A=0xA, B=0xB -> occupancy=2, in_ready=0, out_data=0xA stable;
//     release -> A then B on consecutive cycles.
//  4. Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=2'b00, occupancy=0; input entry dropped.
//  5. SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid -> replacement in 1 cycle.
//  6. Reset asserted mid-stall with occupancy=2 -> cleared next cycle; later entry 0x77 passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: state encoding and register index width.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_BUSY  = ST_BUSY,
    S_FULL  = ST_FULL
  } state_t;

endpackage

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer carrying {ctrl, wreg, data} with valid/ready handshake,
// flush-to-bubble, and an optional skid slot giving a registered in_ready.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned SKID   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [REG_IDX_W-1:0] in_wreg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [DATA_W-1:0]    out_data,
  output logic [REG_IDX_W-1:0] out_wreg,
  output logic [1:0]           occupancy
);

  state_t state_q, state_d;

  logic [CTRL_W-1:0]    main_ctrl_q, skid_ctrl_q;
  logic [REG_IDX_W-1:0] main_wreg_q, skid_wreg_q;
  logic [DATA_W-1:0]    main_data_q, skid_data_q;

  logic in_fire, out_fire;
  logic load_in, load_skid, pop_skid, clear_main;

  assign out_valid = (state_q != S_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_wreg  = main_wreg_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and slot-load decode; flush overrides every handshake event.
  always_comb begin
    state_d    = state_q;
    load_in    = 1'b0;
    load_skid  = 1'b0;
    pop_skid   = 1'b0;
    clear_main = 1'b0;
    if (flush) begin
      state_d    = S_EMPTY;
      clear_main = 1'b1;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_BUSY;
            load_in = 1'b1;
          end
        end
        S_BUSY: begin
          if (in_fire && out_fire) begin
            load_in = 1'b1;
          end else if (in_fire) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d    = S_EMPTY;
            clear_main = 1'b1;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d  = S_BUSY;
            pop_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Slot storage; ctrl/wreg are zeroed on entering EMPTY so a drained stage shows a clean bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_wreg_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_wreg_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_in) begin
        main_ctrl_q <= in_ctrl;
        main_wreg_q <= in_wreg;
        main_data_q <= in_data;
      end else if (pop_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_wreg_q <= skid_wreg_q;
        main_data_q <= skid_data_q;
      end else if (clear_main) begin
        main_ctrl_q <= '0;
        main_wreg_q <= '0;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_wreg_q <= in_wreg;
        skid_data_q <= in_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      // Registered ready: deasserted only while both slots are occupied.
      always_ff @(posedge clk) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= (state_d != S_FULL);
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: SKID=1 and SKID=0 instances checked against a scoreboard.
module tb_pipe_stage_buffer;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [4:0]  wreg;
    logic [63:0] data;
  } entry_t;

  logic clk;
  logic reset;

  logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [1:0]  s1_in_ctrl, s1_out_ctrl, s1_occ;
  logic [63:0] s1_in_data, s1_out_data;
  logic [4:0]  s1_in_wreg, s1_out_wreg;

  logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [1:0]  s0_in_ctrl, s0_out_ctrl, s0_occ;
  logic [63:0] s0_in_data, s0_out_data;
  logic [4:0]  s0_in_wreg, s0_out_wreg;

  int checks = 0;
  int errors = 0;

  entry_t      sb[$];
  logic        prev_stall [2];
  logic [1:0]  prev_c [2];
  logic [4:0]  prev_w [2];
  logic [63:0] prev_d [2];

  pipe_stage_buffer #(.DATA_W(64), .CTRL_W(2), .SKID(1)) dut_skid (
    .clk(clk), .reset(reset), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_ctrl(s1_in_ctrl),
    .in_data(s1_in_data), .in_wreg(s1_in_wreg),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_ctrl(s1_out_ctrl),
    .out_data(s1_out_data), .out_wreg(s1_out_wreg), .occupancy(s1_occ)
  );

  pipe_stage_buffer #(.DATA_W(64), .CTRL_W(2), .SKID(0)) dut_noskid (
    .clk(clk), .reset(reset), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl),
    .in_data(s0_in_data), .in_wreg(s0_in_wreg),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl),
    .out_data(s0_out_data), .out_wreg(s0_out_wreg), .occupancy(s0_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus on the selected instance (s=1: SKID=1, s=0: SKID=0), scoreboarding both ports.
  task automatic cyc(input int s, input logic v, input logic [1:0] c, input logic [63:0] d,
                     input logic [4:0] w, input logic ordy, input logic fl);
    entry_t      e;
    logic        ov, ir, rst;
    logic [1:0]  oc, occ;
    logic [63:0] od;
    logic [4:0]  ow;
    if (s == 1) begin
      s1_in_valid = v; s1_in_ctrl = c; s1_in_data = d; s1_in_wreg = w;
      s1_out_ready = ordy; s1_flush = fl;
      s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_flush = 1'b0;
    end else begin
      s0_in_valid = v; s0_in_ctrl = c; s0_in_data = d; s0_in_wreg = w;
      s0_out_ready = ordy; s0_flush = fl;
      s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_flush = 1'b0;
    end
    #1;
    rst = reset;
    if (s == 1) begin
      ov = s1_out_valid; ir = s1_in_ready; oc = s1_out_ctrl; od = s1_out_data;
      ow = s1_out_wreg; occ = s1_occ;
    end else begin
      ov = s0_out_valid; ir = s0_in_ready; oc = s0_out_ctrl; od = s0_out_data;
      ow = s0_out_wreg; occ = s0_occ;
    end
    checks++;
    if (occ !== 2'(sb.size())) begin
      errors++;
      $display("FAIL occupancy[s=%0d]: got %0d expected %0d", s, occ, sb.size());
    end
    if (ov !== 1'b1) begin
      checks++;
      if (oc !== 2'b00 || ow !== 5'd0) begin
        errors++;
        $display("FAIL bubble_ctrl[s=%0d]: got ctrl=%b wreg=%0d expected 0/0", s, oc, ow);
      end
    end
    if (prev_stall[s]) begin
      checks++;
      if (ov !== 1'b1 || oc !== prev_c[s] || ow !== prev_w[s] || od !== prev_d[s]) begin
        errors++;
        $display("FAIL stall_hold[s=%0d]: got v=%b data=%h expected v=1 data=%h", s, ov, od, prev_d[s]);
      end
    end
    if (!fl && !rst) begin
      if (ov === 1'b1 && ordy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_out[s=%0d]: got data=%h expected no entry", s, od);
        end else begin
          e = sb.pop_front();
          if (od !== e.data || oc !== e.ctrl || ow !== e.wreg) begin
            errors++;
            $display("FAIL out_entry[s=%0d]: got %h/%b/%0d expected %h/%b/%0d",
                     s, od, oc, ow, e.data, e.ctrl, e.wreg);
          end
        end
      end
      if (v && ir === 1'b1) sb.push_back('{ctrl: c, wreg: w, data: d});
    end
    prev_stall[s] = (ov === 1'b1) && !ordy && !fl && !rst;
    prev_c[s] = oc; prev_w[s] = ow; prev_d[s] = od;
    @(negedge clk);
    if (fl || rst) begin
      sb.delete();
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end
  endtask

  task automatic drain(input int s);
    for (int k = 0; k < 8; k++) begin
      if (sb.size() == 0 && ((s == 1) ? s1_out_valid : s0_out_valid) !== 1'b1) break;
      cyc(s, 1'b0, 2'b00, 64'h0, 5'd0, 1'b1, 1'b0);
    end
    checks++;
    if (sb.size() != 0 || ((s == 1) ? s1_out_valid : s0_out_valid) !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout[s=%0d]: got %0d pending expected 0", s, sb.size());
    end
  endtask

  task automatic check_empty(input string name, input int s, input logic chk_data, input logic [63:0] d);
    logic        ov, ir;
    logic [1:0]  oc, occ;
    logic [4:0]  ow;
    logic [63:0] od;
    ov = (s == 1) ? s1_out_valid : s0_out_valid;
    ir = (s == 1) ? s1_in_ready  : s0_in_ready;
    oc = (s == 1) ? s1_out_ctrl  : s0_out_ctrl;
    occ = (s == 1) ? s1_occ      : s0_occ;
    ow = (s == 1) ? s1_out_wreg  : s0_out_wreg;
    od = (s == 1) ? s1_out_data  : s0_out_data;
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1 || oc !== 2'b00 || ow !== 5'd0 || occ !== 2'd0 ||
        (chk_data && od !== d)) begin
      errors++;
      $display("FAIL %s[s=%0d]: got v=%b rdy=%b ctrl=%b wreg=%0d occ=%0d data=%h expected 0/1/0/0/0 data=%h",
               name, s, ov, ir, oc, ow, occ, od, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_empty("reset_state", 1, 1'b1, 64'h0);
    check_empty("reset_state", 0, 1'b1, 64'h0);
    @(negedge clk);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1'b1, 2'b11, 64'h11 + 64'(i), 5'(i + 1), 1'b1, 1'b0);
      checks++;
      if (s1_out_valid !== 1'b1 || s1_out_data !== 64'h11 + 64'(i) || s1_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_latency: got v=%b data=%h rdy=%b expected 1/%h/1",
                 s1_out_valid, s1_out_data, s1_in_ready, 64'h11 + 64'(i));
      end
    end
    drain(1);
  endtask

  task automatic fill_full();
    cyc(1, 1'b1, 2'b01, 64'hA, 5'd10, 1'b0, 1'b0);
    cyc(1, 1'b1, 2'b10, 64'hB, 5'd11, 1'b0, 1'b0);
    checks++;
    if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0 || s1_out_data !== 64'hA || s1_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got occ=%0d rdy=%b data=%h expected 2/0/a", s1_occ, s1_in_ready, s1_out_data);
    end
  endtask

  task automatic test_stall();
    fill_full();
    cyc(1, 1'b1, 2'b11, 64'hEE, 5'd12, 1'b0, 1'b0);
    cyc(1, 1'b0, 2'b00, 64'h0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (s1_out_valid !== 1'b1 || s1_out_data !== 64'hB || s1_out_ctrl !== 2'b10) begin
      errors++;
      $display("FAIL stall_release: got v=%b data=%h expected 1/b", s1_out_valid, s1_out_data);
    end
    cyc(1, 1'b0, 2'b00, 64'h0, 5'd0, 1'b1, 1'b0);
    check_empty("stall_drained", 1, 1'b0, 64'h0);
  endtask

  task automatic test_flush();
    fill_full();
    cyc(1, 1'b1, 2'b11, 64'hCC, 5'd3, 1'b0, 1'b1);
    check_empty("flush_full", 1, 1'b1, 64'hA);
    cyc(1, 1'b1, 2'b10, 64'hD1, 5'd4, 1'b0, 1'b0);
    cyc(1, 1'b1, 2'b11, 64'hD2, 5'd5, 1'b0, 1'b1);
    check_empty("flush_drop_in", 1, 1'b1, 64'hD1);
    cyc(1, 1'b0, 2'b00, 64'h0, 5'd0, 1'b1, 1'b0);
    check_empty("flush_no_ghost", 1, 1'b0, 64'h0);
  endtask

  task automatic test_noskid();
    cyc(0, 1'b1, 2'b01, 64'h21, 5'd6, 1'b0, 1'b0);
    s0_in_valid = 1'b1; s0_in_data = 64'h22; s0_out_ready = 1'b0;
    #1;
    checks++;
    if (s0_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL noskid_stall_ready: got %b expected 0", s0_in_ready);
    end
    cyc(0, 1'b1, 2'b10, 64'h22, 5'd7, 1'b1, 1'b0);
    checks++;
    if (s0_out_valid !== 1'b1 || s0_out_data !== 64'h22 || s0_out_wreg !== 5'd7 || s0_occ !== 2'd1) begin
      errors++;
      $display("FAIL noskid_replace: got v=%b data=%h wreg=%0d occ=%0d expected 1/22/7/1",
               s0_out_valid, s0_out_data, s0_out_wreg, s0_occ);
    end
    drain(0);
  endtask

  task automatic test_reset_mid_stall();
    fill_full();
    reset = 1'b1;
    cyc(1, 1'b0, 2'b00, 64'h0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    check_empty("reset_mid_stall", 1, 1'b1, 64'h0);
    cyc(1, 1'b1, 2'b01, 64'h77, 5'd9, 1'b1, 1'b0);
    checks++;
    if (s1_out_valid !== 1'b1 || s1_out_data !== 64'h77 || s1_out_wreg !== 5'd9) begin
      errors++;
      $display("FAIL post_reset_latency: got v=%b data=%h expected 1/77", s1_out_valid, s1_out_data);
    end
    drain(1);
  endtask

  task automatic test_back_to_back(input int s);
    for (int i = 0; i < 300; i++) begin
      cyc(s, 1'($urandom_range(0, 3) != 0), 2'($urandom), {$urandom, $urandom}, 5'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    drain(s);
  endtask

  initial begin
    reset = 1'b0;
    s1_flush = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b0;
    s1_in_ctrl = '0; s1_in_data = '0; s1_in_wreg = '0;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_in_ctrl = '0; s0_in_data = '0; s0_in_wreg = '0;
    prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_noskid();
    test_reset_mid_stall();
    test_back_to_back(1);
    test_back_to_back(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
